calc_key_sequencer: RTL

- Consumer end of the keyboard key-code path: takes the 4-bit key codes produced by the keyboard decoder and assembles them into a complete calculator request.
- Builds decimal operand A, captures the operator, builds operand B, and on ENTER issues one request to the ALU over a valid/ready handshake.
- Sits between the keyboard block and the ALU/display path.

---
 rtl/calc_pkg.sv | 37 +++
 rtl/calc_key_sequencer_if.sv | 26 ++
 rtl/dec_accumulator.sv | 59 +++++
 rtl/calc_key_sequencer.sv | 136 +++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared key-code constants and enums for the calculator key sequencer.
package calc_pkg;

    localparam logic [3:0] KEY_OP_BASE = 4'd10;
    localparam logic [3:0] KEY_ENTER   = 4'd14;
    localparam logic [3:0] KEY_CLEAR   = 4'd15;

    typedef enum logic [1:0] {
        OP_ADD,
        OP_SUB,
        OP_MUL,
        OP_MOD
    } op_e;

    typedef enum logic [2:0] {
        S_A,
        S_OP,
        S_B,
        S_REQ,
        S_DONE
    } state_e;

    function automatic logic is_digit_code(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

    function automatic logic is_op_code(input logic [3:0] code);
        return (code >= KEY_OP_BASE) && (code < KEY_ENTER);
    endfunction

    function automatic op_e op_of_code(input logic [3:0] code);
        logic [3:0] idx;
        idx = code - KEY_OP_BASE;
        return op_e'(idx[1:0]);
    endfunction

endpackage

// File: rtl/calc_key_sequencer_if.sv
// Key-code input and ALU request bus of the calculator key sequencer.
interface calc_key_sequencer_if #(
    parameter int OPW = 8
);
    logic [3:0]     key_code;
    logic           key_valid;
    logic [OPW-1:0] operand_a;
    logic [OPW-1:0] operand_b;
    logic [1:0]     op_sel;
    logic           req_valid;
    logic           req_ready;
    logic [OPW-1:0] disp_val;
    logic           key_reject;

    // key_valid is a one-cycle strobe; req transfers when req_valid & req_ready at a
    // rising edge, and operand_a/operand_b/op_sel stay stable while req_valid is high.
    modport master (
        output key_code, key_valid, req_ready,
        input  operand_a, operand_b, op_sel, req_valid, disp_val, key_reject
    );

    modport slave (
        input  key_code, key_valid, req_ready,
        output operand_a, operand_b, op_sel, req_valid, disp_val, key_reject
    );
endinterface

// File: rtl/dec_accumulator.sv
// Decimal operand builder: value = value*10 + digit while it fits in OPW bits
// and the digit budget; refused digits raise reject for that cycle.
module dec_accumulator #(
    parameter int OPW        = 8,
    parameter int MAX_DIGITS = 3,
    parameter int CW         = $clog2(MAX_DIGITS + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    input  logic           load_first,
    input  logic [3:0]     digit,
    input  logic           digit_valid,
    output logic [OPW-1:0] value,
    output logic [OPW-1:0] value_nxt,
    output logic [CW-1:0]  count,
    output logic           reject
);
    localparam int WW = OPW + 4;

    logic [WW-1:0] cand;
    logic [CW-1:0] count_nxt;
    logic          fits;

    // Four extra bits hold (2^OPW-1)*10+9 without wrapping.
    assign cand = WW'(value) * WW'(10) + WW'(digit);
    assign fits = (count < CW'(MAX_DIGITS)) && (cand <= WW'({OPW{1'b1}}));

    always_comb begin
        value_nxt = value;
        count_nxt = count;
        reject    = 1'b0;
        if (clear) begin
            value_nxt = '0;
            count_nxt = '0;
        end else if (load_first) begin
            value_nxt = OPW'(digit);
            count_nxt = CW'(1);
        end else if (digit_valid) begin
            if (fits) begin
                value_nxt = cand[OPW-1:0];
                count_nxt = count + CW'(1);
            end else begin
                reject = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= '0;
            count <= '0;
        end else begin
            value <= value_nxt;
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/calc_key_sequencer.sv
// Assembles keyboard key codes into operand A, operator, operand B and issues
// one ALU request per ENTER over a valid/ready handshake.
module calc_key_sequencer
    import calc_pkg::*;
#(
    parameter int OPW        = 8,
    parameter int MAX_DIGITS = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    calc_key_sequencer_if.slave  bus,
    output state_e               state_dbg
);
    localparam int CW = $clog2(MAX_DIGITS + 1);

    state_e         state_q, state_d;
    logic           is_dig, is_op, is_ent, is_clr;
    logic           a_clr, a_load, a_dv, b_clr, b_load, b_dv, op_load, op_clr;
    logic [OPW-1:0] a_val, a_nxt, b_val, b_nxt;
    logic [CW-1:0]  cnt_a, cnt_b;
    logic           rej_a, rej_b;
    op_e            op_q;
    logic           req_q, rej_q;
    logic [OPW-1:0] disp_q;

    assign is_dig = bus.key_valid && is_digit_code(bus.key_code);
    assign is_op  = bus.key_valid && is_op_code(bus.key_code);
    assign is_ent = bus.key_valid && (bus.key_code == KEY_ENTER);
    assign is_clr = bus.key_valid && (bus.key_code == KEY_CLEAR);

    dec_accumulator #(.OPW(OPW), .MAX_DIGITS(MAX_DIGITS), .CW(CW)) u_acc_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (a_clr),
        .load_first  (a_load),
        .digit       (bus.key_code),
        .digit_valid (a_dv),
        .value       (a_val),
        .value_nxt   (a_nxt),
        .count       (cnt_a),
        .reject      (rej_a)
    );

    dec_accumulator #(.OPW(OPW), .MAX_DIGITS(MAX_DIGITS), .CW(CW)) u_acc_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (b_clr),
        .load_first  (b_load),
        .digit       (bus.key_code),
        .digit_valid (b_dv),
        .value       (b_val),
        .value_nxt   (b_nxt),
        .count       (cnt_b),
        .reject      (rej_b)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_A;
        else        state_q <= state_d;
    end

    // S_REQ ignores every key, CLEAR included, until the handshake completes.
    always_comb begin
        state_d = state_q;
        if (state_q != S_REQ && is_clr) begin
            state_d = S_A;
        end else begin
            case (state_q)
                S_A:     if (is_op && cnt_a != '0) state_d = S_OP;
                S_OP:    if (is_dig) state_d = S_B;
                S_B:     if (is_ent && cnt_b != '0) state_d = S_REQ;
                S_REQ:   if (req_q && bus.req_ready) state_d = S_DONE;
                S_DONE:  if (is_dig) state_d = S_A;
                default: state_d = S_A;
            endcase
        end
    end

    always_comb begin
        a_clr   = 1'b0;
        a_load  = 1'b0;
        a_dv    = 1'b0;
        b_clr   = 1'b0;
        b_load  = 1'b0;
        b_dv    = 1'b0;
        op_load = 1'b0;
        op_clr  = 1'b0;
        if (state_q != S_REQ && is_clr) begin
            a_clr  = 1'b1;
            b_clr  = 1'b1;
            op_clr = 1'b1;
        end else begin
            case (state_q)
                S_A: begin
                    a_dv    = is_dig;
                    op_load = is_op && (cnt_a != '0);
                end
                S_OP: begin
                    b_load  = is_dig;
                    op_load = is_op;
                end
                S_B:    b_dv = is_dig;
                S_DONE: begin
                    a_load = is_dig;
                    b_clr  = is_dig;
                end
                default: ;
            endcase
        end
    end

    // Outputs are registered from next-state values so they line up with the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q   <= OP_ADD;
            req_q  <= 1'b0;
            rej_q  <= 1'b0;
            disp_q <= '0;
        end else begin
            if (op_clr)       op_q <= OP_ADD;
            else if (op_load) op_q <= op_of_code(bus.key_code);
            req_q  <= (state_d == S_REQ);
            rej_q  <= rej_a | rej_b;
            disp_q <= (state_d == S_A || state_d == S_OP) ? a_nxt : b_nxt;
        end
    end

    assign bus.operand_a  = a_val;
    assign bus.operand_b  = b_val;
    assign bus.op_sel     = op_q;
    assign bus.req_valid  = req_q;
    assign bus.disp_val   = disp_q;
    assign bus.key_reject = rej_q;
    assign state_dbg      = state_q;

endmodule
